ff_write_scheduler: RTL and testbench
=====================================

# ff_write_scheduler

Round-robin scheduler that shares one WIDTH-bit bank of synchronous enable/set/reset D flip-flops between N requesters. Each requester posts a write command (load, set, clear, or no-op). The block grants one requester at a time, drives the bank's enable, data, set and reset controls for exactly one cycle, and returns a one-cycle acknowledge. It sits between the requesting control logic and the shared register bank, and is the only driver of that bank's control inputs.

## Interface
- N, 4: number of requesters, 2..8
- WIDTH, 8: width of the shared flip-flop bank
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-low
- req  input  N  request, one bit per requester; level, held until ack
- op  input  2*N  per-requester command; requester i uses op[2i+1:2i]; 00 load data, 01 set to all-ones, 10 clear to zero, 11 no-op
- wdata  input  N*WIDTH  per-requester load data; requester i uses wdata[WIDTH*i +: WIDTH]
- gnt  output  N  one-hot grant, high during the commit cycle
- ack  output  N  one-hot acknowledge, one-cycle pulse
- ff_en  output  1  bank enable
- ff_d  output  WIDTH  bank data
- ff_set  output  1  bank synchronous set
- ff_rst  output  1  bank synchronous reset; the bank gives reset priority over set
- busy  output  1  high in any state other than IDLE

## Operation
- All outputs are registered. While rst=0: every output is 0, state is IDLE and the round-robin pointer is 0.
- States:
  - IDLE: all controls are 0.
  - COMMIT: gnt[w]=1 and bank controls are driven from the latched command.
  - ACK: ack[w]=1, gnt=0 and ff_en=0.
- Arbitration:
  - The winner is the first requester with req high, searching from the pointer upward and wrapping from N-1 to 0.
  - On entry to COMMIT, the pointer becomes (w+1) mod N.
- IDLE→COMMIT at the first edge where any req is high. On that edge, op[w] and wdata[w] are latched. Input changes after that edge have no effect on the commit.
- Command decode in COMMIT:
  - load: ff_en=1, ff_d=latched wdata.
  - set: ff_en=1, ff_set=1, ff_d=0.
  - clear: ff_en=1, ff_rst=1, ff_d=0.
  - no-op: ff_en=0, ff_set=0, ff_rst=0, ff_d=0. This still completes the full grant and acknowledge.
- COMMIT→ACK unconditionally after one cycle.
- ACK→COMMIT back-to-back if any requester other than w has req high. Arbitration in this cycle masks requester w, because w's req may still be high while it sees the ack. Otherwise ACK→IDLE.
- Requester protocol: drop req in the cycle after ack. A req still high in the cycle after ack is treated as a new request.
- Reset mid-operation: all outputs clear immediately. The aborted requester gets no ack. Whether the bank edge coincident with reset captured the write is undefined.
- gnt and ack are never high together, and each is at most one-hot.

## Timing
- req rises before edge E0 while in IDLE: COMMIT runs in the cycle after E0, and the bank captures at edge E1.
- ack is high in the cycle after E1. Single-request latency is req to ack in 2 cycles.
- The bank's q reflects the write in the cycle when ack is high.
- Sustained throughput with contending requesters: one commit per 2 cycles.
- busy is high exactly while the state is COMMIT or ACK.

## Test plan
- Reset:
  - Stimulus: hold rst=0 with random req, op and wdata.
  - Required: all outputs 0. After release with req=0, the design stays in IDLE.
- Single load:
  - Stimulus: req=0001, op0=00, wdata0=0xA5.
  - Required: next cycle gnt=0001, ff_en=1, ff_d=0xA5, ff_set=0, ff_rst=0. The following cycle ack=0001 and the bank q=0xA5.
- Set, clear and no-op from requester 2:
  - Set: ff_set=1 and bank q becomes 0xFF.
  - Clear: ff_rst=1 and bank q becomes 0x00.
  - No-op: ff_en=0 and q is unchanged, but ack=0100 still pulses.
- Round-robin fairness:
  - Stimulus: req=1111 held, each requester dropping its bit for one cycle after its ack.
  - Required: grant order 0,1,2,3,0; COMMIT and ACK alternate with no IDLE cycles; no requester is granted twice within 4 grants.
- Masking and wrap:
  - Stimulus: pointer at 3, req=1001, requester 3 keeps req high through its ack cycle.
  - Required: gnt=1000, then ack=1000 with the next gnt=0001. Requester 3 is not regranted back-to-back.
- Reset mid-commit:
  - Stimulus: assert rst=0 while gnt=0010 is high.
  - Required: gnt, ff_en and busy go 0 immediately; ack=0010 never occurs; after release the pointer is 0.

Source files
------------

// File: rtl/ff_write_scheduler.sv
// Round-robin write scheduler for a shared WIDTH-bit enable/set/reset flop bank.
// One requester is committed per grant; the grant is followed by a one-cycle ack.
module ff_write_scheduler #(
   parameter int N     = 4,
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [2*N-1:0]       op,
   input  logic [N*WIDTH-1:0]   wdata,
   output logic [N-1:0]         gnt,
   output logic [N-1:0]         ack,
   output logic                 ff_en,
   output logic [WIDTH-1:0]     ff_d,
   output logic                 ff_set,
   output logic                 ff_rst,
   output logic                 busy
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};
   localparam logic [1:0] OP_LOAD = 2'b00;
   localparam logic [1:0] OP_SET  = 2'b01;
   localparam logic [1:0] OP_CLR  = 2'b10;

   typedef enum logic [1:0] {IDLE, COMMIT, ACK} state_t;

   state_t                   state, state_n;
   logic [PW-1:0]            ptr, ptr_n, w, w_n, win, idx;
   logic [PW:0]              sum;
   logic                     found;
   logic [N-1:0]             cand;
   logic [N-1:0][1:0]        op_a;
   logic [N-1:0][WIDTH-1:0]  wd_a;
   logic [N-1:0]             gnt_n, ack_n;
   logic                     ff_en_n, ff_set_n, ff_rst_n;
   logic [WIDTH-1:0]         ff_d_n;

   assign op_a = op;
   assign wd_a = wdata;

   // In ACK the requester just served may still hold req while it sees its ack.
   always_comb begin
      cand = '0;
      if (state == IDLE)
         cand = req;
      else if (state == ACK)
         cand = req & ~(ONE << w);
   end

   always_comb begin
      found = 1'b0;
      win   = '0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < N; k++) begin
         sum = {1'b0, ptr} + (PW+1)'(k);
         if (sum >= (PW+1)'(N))
            sum = sum - (PW+1)'(N);
         idx = sum[PW-1:0];
         if (!found && cand[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   always_comb begin
      state_n  = state;
      ptr_n    = ptr;
      w_n      = w;
      gnt_n    = '0;
      ack_n    = '0;
      ff_en_n  = 1'b0;
      ff_set_n = 1'b0;
      ff_rst_n = 1'b0;
      ff_d_n   = '0;
      case (state)
         IDLE, ACK: begin
            if (found) begin
               state_n = COMMIT;
               w_n     = win;
               ptr_n   = (win == PW'(N-1)) ? '0 : win + PW'(1);
               gnt_n   = ONE << win;
               // Outputs are registered, so the command is captured here once.
               case (op_a[win])
                  OP_LOAD: begin
                     ff_en_n = 1'b1;
                     ff_d_n  = wd_a[win];
                  end
                  OP_SET: begin
                     ff_en_n  = 1'b1;
                     ff_set_n = 1'b1;
                  end
                  OP_CLR: begin
                     ff_en_n  = 1'b1;
                     ff_rst_n = 1'b1;
                  end
                  default: ;
               endcase
            end else begin
               state_n = IDLE;
            end
         end
         COMMIT: begin
            state_n = ACK;
            ack_n   = ONE << w;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         ptr    <= '0;
         w      <= '0;
         gnt    <= '0;
         ack    <= '0;
         ff_en  <= 1'b0;
         ff_d   <= '0;
         ff_set <= 1'b0;
         ff_rst <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= state_n;
         ptr    <= ptr_n;
         w      <= w_n;
         gnt    <= gnt_n;
         ack    <= ack_n;
         ff_en  <= ff_en_n;
         ff_d   <= ff_d_n;
         ff_set <= ff_set_n;
         ff_rst <= ff_rst_n;
         busy   <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_ff_write_scheduler.sv
// Bench for ff_write_scheduler: directed cases with literal expectations plus a
// randomized run compared cycle by cycle against a transaction-level model.
module tb_ff_write_scheduler;

   localparam int N = 4;
   localparam int W = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [N-1:0]     req = '0;
   logic [2*N-1:0]   op = '0;
   logic [N*W-1:0]   wdata = '0;
   logic [N-1:0]     gnt, ack;
   logic             ff_en, ff_set, ff_rst, busy;
   logic [W-1:0]     ff_d;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   ff_write_scheduler #(.N(N), .WIDTH(W)) dut (
      .clk(clk), .rst(rst), .req(req), .op(op), .wdata(wdata),
      .gnt(gnt), .ack(ack), .ff_en(ff_en), .ff_d(ff_d),
      .ff_set(ff_set), .ff_rst(ff_rst), .busy(busy)
   );

   // the shared bank, reset wins over set
   logic [W-1:0] bq = '0;
   always @(posedge clk) begin
      if (ff_rst)      bq <= '0;
      else if (ff_set) bq <= '1;
      else if (ff_en)  bq <= ff_d;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int pick(input logic [N-1:0] r, input int p, input int ex);
      for (int k = 0; k < N; k++) begin
         int j;
         j = (p + k) % N;
         if (r[j] && j != ex) return j;
      end
      return -1;
   endfunction

   // m_phase: 0 nothing in flight, 1 command being committed, 2 being acknowledged
   int            m_ptr = 0, m_phase = 0, m_w = 0, m_op = 0, m_win = 0;
   logic [W-1:0]  m_data = '0, m_q = '0;
   bit            m_qv = 0;
   logic [N-1:0]  e_gnt = '0, e_ack = '0;
   logic          e_en = 0, e_set = 0, e_rst = 0, e_busy = 0;
   logic [W-1:0]  e_d = '0;

   initial forever begin
      @(posedge clk or negedge rst);
      e_gnt = '0; e_ack = '0; e_en = 0; e_set = 0; e_rst = 0; e_d = '0;
      if (!rst) begin
         m_ptr = 0; m_phase = 0; m_w = 0; m_qv = 0;
      end else if (m_phase == 1) begin
         case (m_op)
            0: m_q = m_data;
            1: m_q = '1;
            2: m_q = '0;
            default: ;
         endcase
         if (m_op != 3) m_qv = 1;
         e_ack   = N'(1 << m_w);
         m_phase = 2;
      end else begin
         m_win = pick(req, m_ptr, (m_phase == 2) ? m_w : -1);
         if (m_win >= 0) begin
            m_phase = 1;
            m_w     = m_win;
            m_ptr   = (m_win + 1) % N;
            m_op    = int'(op[2*m_win +: 2]);
            m_data  = wdata[W*m_win +: W];
            e_gnt   = N'(1 << m_win);
            e_en    = (m_op != 3);
            e_set   = (m_op == 1);
            e_rst   = (m_op == 2);
            e_d     = (m_op == 0) ? m_data : '0;
         end else begin
            m_phase = 0;
         end
      end
      e_busy = (m_phase != 0);
   end

   initial forever begin
      @(negedge clk);
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("ack", 32'(ack), 32'(e_ack));
      chk("ff_en", 32'(ff_en), 32'(e_en));
      chk("ff_set", 32'(ff_set), 32'(e_set));
      chk("ff_rst", 32'(ff_rst), 32'(e_rst));
      chk("ff_d", 32'(ff_d), 32'(e_d));
      chk("busy", 32'(busy), 32'(e_busy));
      if (rst && e_ack != '0 && m_qv) chk("bank_q", 32'(bq), 32'(m_q));
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_req(input int i, input logic [1:0] o, input logic [W-1:0] d);
      op[2*i +: 2]  = o;
      wdata[W*i +: W] = d;
      req[i] = 1'b1;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b0;
      req = '0;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic single(input int i, input logic [1:0] o, input logic [W-1:0] d,
                         input logic x_en, input logic x_set, input logic x_rst,
                         input logic [W-1:0] x_d, input logic [W-1:0] x_q);
      set_req(i, o, d);
      @(negedge clk);
      chk("single gnt", 32'(gnt), 32'(1 << i));
      chk("single ff_en", 32'(ff_en), 32'(x_en));
      chk("single ff_set", 32'(ff_set), 32'(x_set));
      chk("single ff_rst", 32'(ff_rst), 32'(x_rst));
      chk("single ff_d", 32'(ff_d), 32'(x_d));
      op[2*i +: 2]    = ~o;   // must not disturb the latched command
      wdata[W*i +: W] = ~d;
      @(negedge clk);
      chk("single ack", 32'(ack), 32'(1 << i));
      chk("single q", 32'(bq), 32'(x_q));
      req[i] = 1'b0;
      @(negedge clk);
      chk("single idle", 32'(busy), 32'(0));
   endtask

   logic [N-1:0] drop_nx = '0;

   task automatic rand_step();
      for (int i = 0; i < N; i++) begin
         if (drop_nx[i]) begin
            req[i] = 1'b0;
            drop_nx[i] = 1'b0;
         end else if (ack[i]) begin
            if ($urandom_range(0, 1) == 1) drop_nx[i] = 1'b1;
            else req[i] = 1'b0;
         end else if (gnt[i]) begin
            op[2*i +: 2]    = 2'($urandom);
            wdata[W*i +: W] = W'($urandom);
         end else if (!req[i] && $urandom_range(0, 2) == 0) begin
            set_req(i, 2'($urandom), W'($urandom));
         end
      end
   endtask

   // ---------------- main sequence ----------------
   int           order[$];
   int           exp_order[5] = '{0, 1, 2, 3, 0};
   logic [N-1:0] dropped;

   initial begin
      // reset with noisy inputs
      for (int c = 0; c < 3; c++) begin
         req = N'($urandom); op = 8'($urandom); wdata = 32'($urandom);
         @(negedge clk);
         chk("reset gnt", 32'(gnt), 32'(0));
         chk("reset ack", 32'(ack), 32'(0));
         chk("reset ctl", 32'({ff_en, ff_set, ff_rst, busy}), 32'(0));
         chk("reset ff_d", 32'(ff_d), 32'(0));
      end
      req = '0;
      rst = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("post-reset idle", 32'({busy, gnt}), 32'(0));
      end

      single(0, 2'b00, 8'hA5, 1, 0, 0, 8'hA5, 8'hA5);
      single(2, 2'b01, 8'h5A, 1, 1, 0, 8'h00, 8'hFF);
      single(2, 2'b11, 8'h33, 0, 0, 0, 8'h00, 8'hFF);
      single(2, 2'b10, 8'h77, 1, 0, 1, 8'h00, 8'h00);

      // pointer now at 3: wrap plus masking of a held req
      set_req(0, 2'b00, 8'h11);
      set_req(3, 2'b00, 8'h22);
      @(negedge clk);
      chk("wrap gnt3", 32'(gnt), 32'h8);
      @(negedge clk);
      chk("wrap ack3", 32'(ack), 32'h8);
      @(negedge clk);
      chk("wrap gnt0", 32'(gnt), 32'h1);
      req[3] = 1'b0;
      @(negedge clk);
      chk("wrap ack0", 32'(ack), 32'h1);
      chk("wrap q", 32'(bq), 32'h11);
      req[0] = 1'b0;
      @(negedge clk);
      chk("wrap no regrant", 32'({busy, gnt}), 32'(0));

      // round-robin with all requesters contending
      apply_reset();
      for (int i = 0; i < N; i++) set_req(i, 2'b00, W'(8'h10 + i));
      dropped = '0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) if (gnt[i]) order.push_back(i);
         chk("rr busy", 32'(busy), 32'(1));
         req = req | dropped;
         dropped = ack;
         req = req & ~ack;
      end
      req = '0;
      chk("rr grant count", 32'(order.size()), 32'(5));
      for (int k = 0; k < 5 && k < order.size(); k++)
         chk("rr order", 32'(order[k]), 32'(exp_order[k]));
      @(negedge clk);
      chk("rr idle", 32'(busy), 32'(0));

      // reset while requester 1 is committing
      apply_reset();
      set_req(1, 2'b00, 8'hC3);
      @(negedge clk);
      chk("mid gnt", 32'(gnt), 32'h2);
      #2 rst = 1'b0;
      #1;
      chk("mid reset gnt", 32'(gnt), 32'(0));
      chk("mid reset en", 32'(ff_en), 32'(0));
      chk("mid reset busy", 32'(busy), 32'(0));
      req = '0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         chk("mid no ack", 32'(ack), 32'(0));
      end
      rst = 1'b1;
      set_req(1, 2'b00, 8'h3C);
      set_req(2, 2'b00, 8'h96);
      @(negedge clk);
      chk("mid ptr zero", 32'(gnt), 32'h2);
      @(negedge clk);
      chk("mid ack", 32'(ack), 32'h2);
      req = '0;
      @(negedge clk);

      // randomized traffic with occasional asynchronous resets
      drop_nx = '0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if ($urandom_range(0, 499) == 0) begin
            #2 rst = 1'b0;
            req = '0;
            drop_nx = '0;
            @(negedge clk);
            rst = 1'b1;
         end else begin
            rand_step();
         end
      end
      req = '0;
      repeat (4) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
